// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port select,
// access sizes and the latched request record.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned CNT_W = 4;

  // Everything about the granted access except the address, whose width is a parameter.
  typedef struct packed {
    port_e       sel;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch (I) and load/store (D).
// MEM_ARB_ROUND_ROBIN_EN: alternate on ties; otherwise D always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
  input  port_e last_grant,
  output logic  grant_valid,
  output port_e grant_sel
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (i_req && d_req) begin
      grant_sel = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (i_req) begin
      grant_sel = PORT_I;
    end else begin
      grant_sel = PORT_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_sel = (i_req && !d_req) ? PORT_I : PORT_D;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory between fetch and load/store with programmable
// wait states. Tie-break policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_size,
  output logic [31:0]   mem_din,
  output logic          mem_wen,
  input  logic [31:0]   mem_dout,
  output logic          busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic [AW-1:0]      addr_q, addr_d;
  port_e              last_grant_q, last_grant_d;
  logic [31:0]        i_rdata_q, i_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               grant_valid;
  port_e              grant_sel;
  logic               in_access;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      addr_q       <= '0;
      last_grant_q <= PORT_I;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      last_grant_q <= last_grant_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    // NOTE: hold values assigned first so no branch leaves a signal unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    addr_d       = addr_q;
    last_grant_d = last_grant_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_d.sel    = grant_sel;
          last_grant_d = grant_sel;
          if (grant_sel == PORT_I) begin
            addr_d       = i_addr;
            req_d.size   = SZ_WORD;
            req_d.we     = 1'b0;
            req_d.wdata  = '0;
          end else begin
            addr_d       = d_addr;
            req_d.size   = d_size;
            req_d.we     = d_we;
            req_d.wdata  = d_wdata;
          end
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Writes capture too; the returned value is simply ignored by the requester.
          if (req_q.sel == PORT_I) i_rdata_d = mem_dout;
          else                     d_rdata_d = mem_dout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign mem_addr  = in_access ? addr_q       : '0;
  assign mem_size  = in_access ? req_q.size   : '0;
  assign mem_din   = in_access ? req_q.wdata  : '0;
  // Low only in the last ACCESS cycle, so memory sees exactly one negedge write.
  assign mem_wen   = ~(in_access && (cnt_q == '0) && req_q.we);

  assign i_ack   = (state_q == DONE) && (req_q.sel == PORT_I);
  assign d_ack   = (state_q == DONE) && (req_q.sel == PORT_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance A (WAIT_STATES=2) for directed accesses, instance B
// (WAIT_STATES=0) for the back-to-back streaming/starvation case.
module tb_mem_port_arbiter;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  logic clk, rst;

  logic        i_req, d_req, d_we, i_ack, d_ack, mem_wen, busy;
  logic [1:0]  d_size, mem_size;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  logic        b_i_req, b_d_req, b_d_we, b_i_ack, b_d_ack, b_mem_wen, b_busy;
  logic [1:0]  b_d_size, b_mem_size;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;

  logic [7:0] mem [0:1][0:255];
  int cyc = 0;
  int wen_lo_a = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port_d;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  mem_port_arbiter #(.WAIT_STATES(WS_A), .AW(32)) u_dut_a (
    .CLK(clk), .RST(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_din(mem_din), .mem_wen(mem_wen),
    .mem_dout(mem_dout), .busy(busy)
  );

  mem_port_arbiter #(.WAIT_STATES(WS_B), .AW(32)) u_dut_b (
    .CLK(clk), .RST(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_size(b_mem_size), .mem_din(b_mem_din), .mem_wen(b_mem_wen),
    .mem_dout(b_mem_dout), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian byte memory; narrow reads are zero-filled, 2'b11 behaves as word.
  function automatic logic [31:0] rd(input int m, input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] b;
    b = a[7:0];
    case (sz)
      2'b00:   rd = {24'h0, mem[m][b]};
      2'b01:   rd = {16'h0, mem[m][b + 8'd1], mem[m][b]};
      default: rd = {mem[m][b + 8'd3], mem[m][b + 8'd2], mem[m][b + 8'd1], mem[m][b]};
    endcase
  endfunction

  function automatic void wr(input int m, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] d);
    logic [7:0] b;
    b = a[7:0];
    mem[m][b] = d[7:0];
    if (sz != 2'b00) mem[m][b + 8'd1] = d[15:8];
    if (sz[1]) begin
      mem[m][b + 8'd2] = d[23:16];
      mem[m][b + 8'd3] = d[31:24];
    end
  endfunction

  assign mem_dout   = rd(0, mem_addr, mem_size);
  assign b_mem_dout = rd(1, b_mem_addr, b_mem_size);

  initial begin
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 256; k++) mem[m][k] = 8'h00;
    wr(0, 32'h00, 2'b10, 32'h0BADF00D);
    wr(0, 32'h10, 2'b10, 32'hDEADBEEF);
    wr(0, 32'h30, 2'b10, 32'hA1B2C3D4);
    wr(0, 32'h40, 2'b10, 32'hCAFEF00D);
    wr(0, 32'h50, 2'b10, 32'h55555555);
    wr(1, 32'h00, 2'b10, 32'h11111111);
    wr(1, 32'h04, 2'b10, 32'h22222222);
    wr(1, 32'h08, 2'b10, 32'h33333333);
    wr(1, 32'h80, 2'b10, 32'h8080F00D);
    forever begin
      @(negedge clk);
      if (!mem_wen) begin
        wr(0, mem_addr, mem_size, mem_din);
        wen_lo_a++;
      end
      if (!b_mem_wen) wr(1, b_mem_addr, b_mem_size, b_mem_din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for ack", what);
  endtask

  function automatic void push(input int which, input bit pd, input logic [31:0] d,
                               input bit chk, input int c);
    exp_t e;
    e = '{port_d: pd, data: d, chk: chk, cyc: c};
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
  endfunction

  task automatic sb_pop(input int which, input logic [1:0] acks, input logic [31:0] data);
    exp_t e;
    bit   empty;
    empty = (which == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_ack: got acks %b, expected none", (which == 0) ? "a" : "b", acks);
    end else begin
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      check((which == 0) ? "a_ack_port" : "b_ack_port", 32'(acks), e.port_d ? 32'd2 : 32'd1);
      if (e.chk) check((which == 0) ? "a_rdata" : "b_rdata", data, e.data);
      check((which == 0) ? "a_ack_cycle" : "b_ack_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: pops the scoreboard whenever either instance presents an ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_ack || d_ack)     sb_pop(0, {d_ack, i_ack}, d_ack ? d_rdata : i_rdata);
      if (b_i_ack || b_d_ack) sb_pop(1, {b_d_ack, b_i_ack}, b_d_ack ? b_d_rdata : b_i_rdata);
    end
  end

  task automatic d_issue(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input bit chk);
    @(posedge clk); #1;
    d_we = we; d_size = sz; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    push(0, 1'b1, exp, chk, cyc + WS_A + 2);
  endtask

  task automatic d_wait();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (d_ack) begin d_req = 1'b0; done = 1'b1; end
    end
    if (!done) begin d_req = 1'b0; timeout("a_d_ack"); end
  endtask

  task automatic i_wait();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (i_ack) begin i_req = 1'b0; done = 1'b1; end
    end
    if (!done) begin i_req = 1'b0; timeout("a_i_ack"); end
  endtask

  initial begin
    int p, nd, ni, i_target, w0;
    rst = 1'b1;
    {i_req, d_req, d_we, b_i_req, b_d_req, b_d_we} = '0;
    {d_size, b_d_size} = '0;
    {i_addr, d_addr, d_wdata, b_i_addr, b_d_addr, b_d_wdata} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd1);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;

    // Word load, latency and data.
    d_issue(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    d_wait();

    // Byte store then word load around it: one write pulse, byte lands in lane 1.
    w0 = wen_lo_a;
    d_issue(1'b1, 2'b00, 32'h21, 32'h000000A5, 32'h0, 1'b0);
    d_wait();
    check("store_wen_pulses", 32'(wen_lo_a - w0), 32'd1);
    d_issue(1'b0, 2'b10, 32'h20, 32'h0, 32'h0000A500, 1'b1);
    d_wait();
    d_issue(1'b0, 2'b00, 32'h21, 32'h0, 32'h000000A5, 1'b1);
    d_wait();

    // Simultaneous requests; last_grant is D at this point.
    @(posedge clk); #1;
    i_addr = 32'h0; d_addr = 32'h40; d_we = 1'b0; d_size = 2'b10;
    i_req = 1'b1; d_req = 1'b1; p = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push(0, 1'b0, 32'h0BADF00D, 1'b1, p + WS_A + 2);
    push(0, 1'b1, 32'hCAFEF00D, 1'b1, p + 2 * WS_A + 5);
`else
    push(0, 1'b1, 32'hCAFEF00D, 1'b1, p + WS_A + 2);
    push(0, 1'b0, 32'h0BADF00D, 1'b1, p + 2 * WS_A + 5);
`endif
    for (int n = 0; n < 40 && (i_req || d_req); n++) begin
      @(negedge clk);
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    if (i_req || d_req) begin i_req = 1'b0; d_req = 1'b0; timeout("a_both"); end

    // Address changed after grant must not affect the access.
    d_issue(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    d_addr = 32'h50;
    #4;
    check("latched_addr", mem_addr, 32'h10);
    d_wait();

    // Size 2'b11 passes through; fetch withdrawn after grant still completes.
    d_issue(1'b0, 2'b11, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    check("size11_pass", 32'(mem_size), 32'd3);
    d_wait();
    @(posedge clk); #1;
    i_addr = 32'h40; i_req = 1'b1;
    push(0, 1'b0, 32'hCAFEF00D, 1'b1, cyc + WS_A + 2);
    @(posedge clk); #1;
    i_req = 1'b0;
    i_wait();

    // Reset in the middle of a store: no write, no ack, outputs cleared at once.
    w0 = wen_lo_a;
    @(posedge clk); #1;
    d_we = 1'b1; d_size = 2'b10; d_addr = 32'h30; d_wdata = 32'h12345678; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_din", mem_din, 32'h12345678);
    #2;
    rst = 1'b1; d_req = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wen", 32'(mem_wen), 32'd1);
    check("rst_mid_bus", mem_addr | mem_din | 32'(mem_size), 32'h0);
    check("rst_mid_rdata", i_rdata | d_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_no_write", 32'(wen_lo_a - w0), 32'd0);
    check("rst_mem_kept", rd(0, 32'h30, 2'b10), 32'hA1B2C3D4);
    d_issue(1'b0, 2'b10, 32'h30, 32'h0, 32'hA1B2C3D4, 1'b1);
    d_wait();

    // Instance B: D streams three loads while I is held high the whole time.
    @(posedge clk); #1;
    b_d_we = 1'b0; b_d_size = 2'b10; b_d_addr = 32'h0; b_i_addr = 32'h80;
    b_i_req = 1'b1; b_d_req = 1'b1; p = cyc; nd = 0; ni = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    i_target = 2;
    push(1, 1'b1, 32'h11111111, 1'b1, p + WS_B + 2);
    push(1, 1'b0, 32'h8080F00D, 1'b1, p + WS_B + 5);
    push(1, 1'b1, 32'h22222222, 1'b1, p + WS_B + 8);
    push(1, 1'b0, 32'h8080F00D, 1'b1, p + WS_B + 11);
    push(1, 1'b1, 32'h33333333, 1'b1, p + WS_B + 14);
`else
    i_target = 1;
    push(1, 1'b1, 32'h11111111, 1'b1, p + WS_B + 2);
    push(1, 1'b1, 32'h22222222, 1'b1, p + WS_B + 5);
    push(1, 1'b1, 32'h33333333, 1'b1, p + WS_B + 8);
    push(1, 1'b0, 32'h8080F00D, 1'b1, p + WS_B + 11);
`endif
    for (int n = 0; n < 60 && (b_i_req || b_d_req); n++) begin
      @(negedge clk);
      if (b_d_ack) begin
        nd++;
        if (nd == 3) b_d_req = 1'b0;
        else         b_d_addr = 32'(nd * 4);
      end
      if (b_i_ack) begin
        ni++;
        if (ni == i_target) b_i_req = 1'b0;
      end
    end
    if (b_i_req || b_d_req) begin b_i_req = 1'b0; b_d_req = 1'b0; timeout("b_stream"); end

    repeat (6) @(posedge clk);
    #1;
    check("a_sb_drained", 32'(q_a.size()), 32'd0);
    check("b_sb_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
